// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: sequences one load/store at a time onto a
// request/ready/rvalid bus, stalls the pipeline meanwhile, and formats load data.
module dmem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wdata,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_misaligned,
  output logic        mem_bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [1:0]  lo_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic        mis_raw;
  logic        acc;
  logic        hs;
  logic        tmo;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;

  // Shift the addressed lane down, then sign- or zero-extend to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh = rdata >> {lo, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0: begin
        ext = b;
        fmt_load = uns ? {24'd0, sh[7:0]} : ext;
      end
      2'd1: begin
        ext = h;
        fmt_load = uns ? {16'd0, sh[15:0]} : ext;
      end
      default: fmt_load = sh;
    endcase
  endfunction

  always_comb begin
    mis_raw = ((ex_mem_size == 2'd1) && ex_mem_addr[0]) ||
              (ex_mem_size[1] && (ex_mem_addr[1:0] != 2'b00));
    acc     = (ex_mem_rd || ex_mem_wr) && !mis_raw;
    hs      = ((state == REQ) && bus_ready) || ((state == RESP) && bus_rvalid);
    tmo     = ((state == REQ) || (state == RESP)) && (cnt == LAST) && !hs;
    mem_misaligned = rst && (state == IDLE) && (ex_mem_rd || ex_mem_wr) && mis_raw;
    mem_stall = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    mem_stall = acc;
        REQ:     mem_stall = !(bus_ready && bus_we) && !tmo;
        RESP:    mem_stall = !bus_rvalid && !tmo;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (ex_mem_size)
      2'd0: begin
        strb_n  = 4'b0001 << ex_mem_addr[1:0];
        wdata_n = {4{ex_mem_wdata[7:0]}};
      end
      2'd1: begin
        strb_n  = 4'b0011 << ex_mem_addr[1:0];
        wdata_n = {2{ex_mem_wdata[15:0]}};
      end
      default: begin
        strb_n  = 4'b1111;
        wdata_n = ex_mem_wdata;
      end
    endcase
  end

  assign bus_req = (state == REQ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      lo_r           <= 2'd0;
      size_r         <= 2'd0;
      uns_r          <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= 32'd0;
      bus_wdata      <= 32'd0;
      bus_wstrb      <= 4'd0;
      mem_load_data  <= 32'd0;
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
    end else begin
      mem_load_valid <= 1'b0;
      mem_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            // A simultaneous rd+wr is treated as a load; the store is dropped.
            state     <= REQ;
            cnt       <= 8'd0;
            lo_r      <= ex_mem_addr[1:0];
            size_r    <= ex_mem_size;
            uns_r     <= ex_mem_unsigned;
            bus_we    <= !ex_mem_rd;
            bus_addr  <= {ex_mem_addr[31:2], 2'b00};
            bus_wdata <= wdata_n;
            bus_wstrb <= ex_mem_rd ? 4'd0 : strb_n;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_ready) begin
            state <= bus_we ? IDLE : RESP;
          end else if (tmo) begin
            state       <= IDLE;
            mem_bus_err <= 1'b1;
          end
        end
        RESP: begin
          cnt <= cnt + 8'd1;
          if (bus_rvalid) begin
            state          <= IDLE;
            mem_load_data  <= fmt_load(bus_rdata, lo_r, size_r, uns_r);
            mem_load_valid <= 1'b1;
          end else if (tmo) begin
            state       <= IDLE;
            mem_bus_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (TIMEOUT_CYC=4): loads, stores, extension,
// misalignment, timeout, back-to-back and mid-access reset.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wdata;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] mem_load_data;
  logic        mem_load_valid;
  logic        mem_misaligned;
  logic        mem_bus_err;

  int checks = 0;
  int passes = 0;

  dmem_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_addr(ex_mem_addr),
    .ex_mem_wdata(ex_mem_wdata), .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .mem_load_data(mem_load_data), .mem_load_valid(mem_load_valid),
    .mem_misaligned(mem_misaligned), .mem_bus_err(mem_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_in();
    ex_mem_rd = 0; ex_mem_wr = 0; ex_mem_addr = 0; ex_mem_wdata = 0;
    ex_mem_size = 0; ex_mem_unsigned = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Drives a load with ready in cycle 1 and rvalid in cycle 2; reports what it saw.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, output logic [31:0] data,
                          output int lat, output int stalls);
    ex_mem_rd = 1; ex_mem_wr = 0; ex_mem_addr = addr; ex_mem_size = size; ex_mem_unsigned = uns;
    stalls = 0; lat = -1; data = 32'hx;
    for (int c = 0; c < 7; c++) begin
      bus_ready = (c == 1); bus_rvalid = (c == 2); bus_rdata = rdata;
      if (c >= 3) ex_mem_rd = 0;
      @(negedge clk);
      if (mem_stall) stalls++;
      if (mem_load_valid && lat < 0) begin lat = c; data = mem_load_data; end
      next_cyc();
    end
    idle_in();
  endtask

  task automatic test_reset();
    rst = 0; idle_in();
    ex_mem_rd = 1; ex_mem_addr = 32'h1002; ex_mem_size = 2;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else passes++;
    checks++; if (mem_misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b want 0", mem_misaligned); else passes++;
    next_cyc();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req: got %b want 0", bus_req); else passes++;
    checks++; if ({bus_we, bus_addr, bus_wdata, bus_wstrb} !== 69'd0)
      $display("FAIL reset_bus_out: got we=%b addr=%h wdata=%h strb=%b want zeros", bus_we, bus_addr, bus_wdata, bus_wstrb); else passes++;
    checks++; if ({mem_load_valid, mem_bus_err, mem_load_data} !== 34'd0)
      $display("FAIL reset_mem_out: got v=%b err=%b data=%h want zeros", mem_load_valid, mem_bus_err, mem_load_data); else passes++;
    next_cyc();
    rst = 1; idle_in();
    next_cyc();
  endtask

  task automatic test_word_load();
    logic req1, stall0, stall1, stall2;
    logic [31:0] addr1; logic [3:0] strb1;
    ex_mem_rd = 1; ex_mem_addr = 32'h1000; ex_mem_size = 2;
    @(negedge clk); stall0 = mem_stall; next_cyc();
    bus_ready = 1;
    @(negedge clk); stall1 = mem_stall; req1 = bus_req; addr1 = bus_addr; strb1 = bus_wstrb; next_cyc();
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk); stall2 = mem_stall; next_cyc();
    idle_in();
    @(negedge clk);
    checks++; if ({stall0, stall1, stall2} !== 3'b110) $display("FAIL wl_stall: got %b want 110", {stall0, stall1, stall2}); else passes++;
    checks++; if (req1 !== 1'b1 || addr1 !== 32'h1000) $display("FAIL wl_req_addr: got req=%b addr=%h want 1/00001000", req1, addr1); else passes++;
    checks++; if (strb1 !== 4'b0000) $display("FAIL wl_strb: got %b want 0000", strb1); else passes++;
    checks++; if (mem_load_valid !== 1'b1 || mem_load_data !== 32'hDEADBEEF)
      $display("FAIL wl_data: got v=%b data=%h want 1/deadbeef", mem_load_valid, mem_load_data); else passes++;
    next_cyc();
    @(negedge clk);
    checks++; if (mem_load_valid !== 1'b0) $display("FAIL wl_pulse: got %b want 0", mem_load_valid); else passes++;
    next_cyc();
  endtask

  task automatic test_byte_store();
    int stalls = 0;
    ex_mem_wr = 1; ex_mem_addr = 32'h2003; ex_mem_wdata = 32'h000000A5; ex_mem_size = 0;
    for (int c = 0; c < 6; c++) begin
      bus_ready = (c == 4);
      if (c == 5) ex_mem_wr = 0;
      @(negedge clk);
      if (mem_stall) stalls++;
      if (c == 1) begin
        checks++; if (bus_wdata !== 32'hA5A5A5A5) $display("FAIL bs_wdata: got %h want a5a5a5a5", bus_wdata); else passes++;
        checks++; if (bus_wstrb !== 4'b1000) $display("FAIL bs_strb: got %b want 1000", bus_wstrb); else passes++;
        checks++; if (bus_addr !== 32'h2000 || bus_we !== 1'b1) $display("FAIL bs_addr_we: got %h/%b want 00002000/1", bus_addr, bus_we); else passes++;
      end
      if (c == 5) begin
        checks++; if (bus_req !== 1'b0 || mem_bus_err !== 1'b0) $display("FAIL bs_done: got req=%b err=%b want 0/0", bus_req, mem_bus_err); else passes++;
      end
      next_cyc();
    end
    checks++; if (stalls != 4) $display("FAIL bs_stall_cycles: got %0d want 4", stalls); else passes++;
    idle_in();
  endtask

  task automatic test_extend();
    logic [31:0] addrs [4] = '{32'h3000, 32'h3000, 32'h3002, 32'h3002};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [4] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80F0, 32'h000080F0};
    logic [31:0] data; int lat; int stalls;
    for (int i = 0; i < 4; i++) begin
      run_load(addrs[i], sizes[i], unss[i], 32'h80F07F81, data, lat, stalls);
      checks++; if (data !== exps[i] || lat != 3) $display("FAIL ext_%0d: got %h at cycle %0d want %h at 3", i, data, lat, exps[i]); else passes++;
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2] = '{32'h1002, 32'h1001};
    logic [1:0]  sizes [2] = '{2'd2, 2'd1};
    int mis, req, stall;
    for (int i = 0; i < 2; i++) begin
      mis = 0; req = 0; stall = 0;
      ex_mem_rd = (i == 0); ex_mem_wr = (i == 1); ex_mem_addr = addrs[i]; ex_mem_size = sizes[i];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (mem_misaligned === 1'b1) mis++;
        if (bus_req !== 1'b0) req++;
        if (mem_stall !== 1'b0) stall++;
        next_cyc();
      end
      idle_in();
      checks++; if (mis != 3) $display("FAIL mis_flag_%0d: got %0d/3 cycles flagged want 3", i, mis); else passes++;
      checks++; if (req != 0 || stall != 0) $display("FAIL mis_quiet_%0d: got req=%0d stall=%0d cycles want 0/0", i, req, stall); else passes++;
    end
  endtask

  task automatic test_timeout();
    int reqs = 0, stalls = 0, errs = 0, err_cyc = -1, last_stall = -1;
    logic [31:0] data; int lat; int ls;
    ex_mem_rd = 1; ex_mem_addr = 32'h4000; ex_mem_size = 2;
    for (int c = 0; c < 10; c++) begin
      if (c >= 5) ex_mem_rd = 0;
      @(negedge clk);
      if (bus_req) reqs++;
      if (mem_stall) begin stalls++; last_stall = c; end
      if (mem_bus_err) begin errs++; if (err_cyc < 0) err_cyc = c; end
      next_cyc();
    end
    idle_in();
    checks++; if (reqs != 4) $display("FAIL to_req_cycles: got %0d want 4", reqs); else passes++;
    checks++; if (stalls != 4 || last_stall != 3) $display("FAIL to_stall: got %0d ending %0d want 4 ending 3", stalls, last_stall); else passes++;
    checks++; if (errs != 1 || err_cyc != 5) $display("FAIL to_err: got %0d pulses at %0d want 1 at 5", errs, err_cyc); else passes++;
    run_load(32'h4004, 2'd2, 1'b0, 32'h13579BDF, data, lat, ls);
    checks++; if (data !== 32'h13579BDF || lat != 3 || ls != 2)
      $display("FAIL to_after_load: got %h lat %0d stalls %0d want 13579bdf/3/2", data, lat, ls); else passes++;
  endtask

  task automatic test_back_to_back();
    logic s1, s2, s3, s4;
    ex_mem_wr = 1; ex_mem_addr = 32'h6002; ex_mem_wdata = 32'h0000BEEF; ex_mem_size = 1;
    next_cyc();
    bus_ready = 1;
    @(negedge clk); s1 = mem_stall;
    checks++; if (bus_wdata !== 32'hBEEFBEEF || bus_wstrb !== 4'b1100 || bus_addr !== 32'h6000)
      $display("FAIL b2b_half_store: got %h/%b/%h want beefbeef/1100/00006000", bus_wdata, bus_wstrb, bus_addr); else passes++;
    next_cyc();
    bus_ready = 0; ex_mem_rd = 1; ex_mem_wr = 1; ex_mem_addr = 32'h6008; ex_mem_size = 2;
    @(negedge clk); s2 = mem_stall; next_cyc();
    bus_ready = 1;
    @(negedge clk); s3 = mem_stall;
    checks++; if (bus_we !== 1'b0 || bus_wstrb !== 4'b0000 || bus_addr !== 32'h6008)
      $display("FAIL b2b_load_wins: got we=%b strb=%b addr=%h want 0/0000/00006008", bus_we, bus_wstrb, bus_addr); else passes++;
    next_cyc();
    bus_ready = 0; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); s4 = mem_stall; next_cyc();
    idle_in();
    @(negedge clk);
    checks++; if ({s1, s2, s3, s4} !== 4'b0110) $display("FAIL b2b_stall: got %b want 0110", {s1, s2, s3, s4}); else passes++;
    checks++; if (mem_load_valid !== 1'b1 || mem_load_data !== 32'hCAFEF00D)
      $display("FAIL b2b_load: got v=%b data=%h want 1/cafef00d", mem_load_valid, mem_load_data); else passes++;
    next_cyc();
  endtask

  task automatic test_reset_mid();
    int valids = 0, errs = 0;
    logic [31:0] data; int lat; int ls;
    ex_mem_rd = 1; ex_mem_addr = 32'h5000; ex_mem_size = 2;
    next_cyc();
    bus_ready = 1; next_cyc();
    bus_ready = 0; rst = 0;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) $display("FAIL rm_stall_forced: got %b want 0", mem_stall); else passes++;
    next_cyc();
    rst = 1; ex_mem_rd = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) $display("FAIL rm_bus_req: got %b want 0", bus_req); else passes++;
    next_cyc();
    bus_rvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_load_valid) valids++;
      if (mem_bus_err) errs++;
      next_cyc();
    end
    checks++; if (valids != 0 || errs != 0) $display("FAIL rm_no_pulse: got valid=%0d err=%0d want 0/0", valids, errs); else passes++;
    run_load(32'h1000, 2'd2, 1'b0, 32'hDEADBEEF, data, lat, ls);
    checks++; if (data !== 32'hDEADBEEF || lat != 3 || ls != 2)
      $display("FAIL rm_next_load: got %h lat %0d stalls %0d want deadbeef/3/2", data, lat, ls); else passes++;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_extend();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the MEM stage. It takes load/store requests from the EX/MEM boundary and sequences them onto a single-outstanding request/ready/rvalid data bus. It stalls the pipeline while an access is in flight and formats byte lanes for stores and sign/zero-extends load data. It also flags misaligned accesses and bus timeouts to the exception logic.

## Interface
- `TIMEOUT_CYC`, 255: max cycles spent in REQ+RESP before abort; 8-bit counter, legal 1..255.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-low (asserted when 0).
- `ex_mem_rd`  in  1  load request, held stable while `mem_stall`=1.
- `ex_mem_wr`  in  1  store request, held stable while `mem_stall`=1.
- `ex_mem_addr`  in  32  byte address.
- `ex_mem_wdata`  in  32  store data (low bits significant).
- `ex_mem_size`  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- `ex_mem_unsigned`  in  1  zero-extend load (LBU/LHU).
- `bus_req`  out  1  access request.
- `bus_we`  out  1  1=write.
- `bus_addr`  out  32  word address: captured addr with [1:0]=0.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte strobes (0 for reads).
- `bus_ready`  in  1  request accepted.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.
- `mem_stall`  out  1  hold IF/ID/EX (combinational).
- `mem_load_data`  out  32  formatted load result (registered).
- `mem_load_valid`  out  1  one-cycle pulse with `mem_load_data`.
- `mem_misaligned`  out  1  combinational misaligned-access flag.
- `mem_bus_err`  out  1  one-cycle timeout pulse (registered).

## Operation
- FSM states: IDLE, REQ, RESP.
- Access: `acc` = (`ex_mem_rd` | `ex_mem_wr`) & !`mem_misaligned`.
  - If both rd and wr are set, the load wins and the store is dropped.
- Misaligned condition: half with addr[0]=1, or word with addr[1:0]≠0.
  - `mem_misaligned`=1 only while the FSM is in IDLE.
  - No bus access and no stall.
- IDLE
  - On `acc`: capture addr, we, size, unsigned, wdata lanes and strobes; go to REQ; clear the counter.
  - `mem_stall`=`acc`.
- REQ
  - `bus_req`=1.
  - On `bus_ready`:
    - Store: go to IDLE; `mem_stall`=0 this cycle.
    - Load: go to RESP.
  - Otherwise `mem_stall`=1.
- RESP
  - On `bus_rvalid`: register formatted data; pulse `mem_load_valid` next cycle; go to IDLE; `mem_stall`=0 this cycle.
- Timeout
  - The counter increments each cycle in REQ/RESP.
  - When counter==`TIMEOUT_CYC`-1 and there is no handshake that cycle: go to IDLE, pulse `mem_bus_err` next cycle, and drop `mem_stall` that cycle.
  - A handshake in the same cycle wins over timeout.
- Store strobes
  - byte: 4'b0001<<a[1:0]
  - half: 4'b0011<<a[1:0]
  - word: 4'b1111
- Store data
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data
  - Shift = `bus_rdata`>>(8*a[1:0]).
  - Take 8/16/32 bits; sign-extend unless `unsigned`.
- Bus outputs (`bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`) are registered and valid while `bus_req`=1.
- `bus_ready` outside REQ and `bus_rvalid` outside RESP are ignored.

## Timing
- Reset values:
  - state=IDLE
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0
  - `mem_load_data`=0, `mem_load_valid`=0, `mem_bus_err`=0
  - counter=0
  - `mem_stall`=0 and `mem_misaligned`=0 are forced during reset.
- Reset mid-access: abandon immediately; `bus_req` low the next cycle; no valid or err pulse.
- Minimum store: cycle 0 IDLE (stall), cycle 1 REQ+ready (no stall). Adds 1 stall cycle.
- Minimum load: cycle 0 IDLE, cycle 1 REQ+ready, cycle 2 RESP+rvalid (no stall), cycle 3 `mem_load_valid`=1. Adds 2 stall cycles.
- Back-to-back: a new access is accepted in the IDLE cycle immediately after completion.
- No combinational path from bus inputs to bus outputs. `mem_stall` depends combinationally on `bus_ready` and `bus_rvalid`.

## Test plan
- Word load, addr 0x1000, ready in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF:
  - `bus_addr`=0x1000, `bus_wstrb`=0.
  - Stall high in cycles 0-1.
  - `mem_load_valid` pulse in cycle 3 with data 0xDEADBEEF.
- Byte store, addr 0x2003, wdata 0x000000A5, ready delayed 3 cycles:
  - `bus_wdata`=0xA5A5A5A5, `bus_wstrb`=4'b1000, `bus_addr`=0x2000.
  - Stall for 4 cycles, then IDLE.
- Sign/zero extension, rdata 0x80F0_7F81:
  - LB at +0 → 0xFFFFFF81.
  - LBU at +0 → 0x00000081.
  - LH at +2 → 0xFFFF80F0.
  - LHU at +2 → 0x000080F0.
- Misaligned: LW at 0x1002 and SH at 0x1001:
  - `mem_misaligned`=1, `bus_req` never asserted, `mem_stall`=0.
- Timeout with `TIMEOUT_CYC`=4, `bus_ready` held 0:
  - `bus_req` high for 4 cycles.
  - `mem_bus_err` pulse one cycle after the fourth REQ cycle; stall released.
  - A following load completes normally.
- Reset (`rst`=0) during RESP, rvalid arrives after reset:
  - `bus_req`=0, no `mem_load_valid`.
  - Next load after release behaves as in the first test.
